// File: rtl/iir_sos_pkg.sv
// Shared definitions for the SOS cascade: coefficient slot layout,
// sequencer state encoding, accumulator control and the fixed-point
// round-and-saturate helper.
package iir_sos_pkg;

  // Coefficient slots within one section (address = stage*N_COEF + idx).
  localparam int IDX_B0   = 0;
  localparam int IDX_B1   = 1;
  localparam int IDX_B2   = 2;
  localparam int IDX_A1   = 3;
  localparam int IDX_A2   = 4;
  localparam int IDX_GAIN = 5;
  localparam int N_COEF   = 6;

  // One section is evaluated in seven steps: five MACs, a gain multiply, a store.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_MAC4,
    ST_GAIN,
    ST_STORE
  } iir_state_e;

  // Accumulator control: LOAD replaces the sum with the current product.
  typedef enum logic [1:0] {
    MAC_HOLD,
    MAC_LOAD,
    MAC_ADD,
    MAC_SUB
  } mac_op_e;

  // Round half up at bit 'frac', then clamp to a signed 'out_w'-bit range.
  // Works on 64-bit values so any accumulator up to 64 bits can be passed in;
  // callers cast the result down to their sample width.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] val,
                                                   input int frac,
                                                   input int out_w);
    logic signed [63:0] rnd;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (val + (64'sd1 <<< (frac - 1))) >>> frac;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (rnd > hi) begin
      return hi;
    end else if (rnd < lo) begin
      return lo;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/sos_mac.sv
// Single signed multiplier feeding a wide accumulator. The rounded and
// saturated view of the accumulator is always available on rs_o; it is the
// section's pre-gain value after the MAC steps and the section output after
// the gain step.
module sos_mac
  import iir_sos_pkg::*;
#(
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 22,
  parameter int COEF_FRAC = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  mac_op_e                     op_i,
  input  logic signed [DATA_SIZE-1:0] a_i,
  input  logic signed [COEF_SIZE-1:0] b_i,
  output logic signed [DATA_SIZE-1:0] rs_o
);

  localparam int PROD_W = DATA_SIZE + COEF_SIZE;
  localparam int ACC_W  = DATA_SIZE + COEF_SIZE + 4;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  assign prod     = PROD_W'(a_i) * PROD_W'(b_i);
  assign prod_ext = ACC_W'(prod);
  assign rs_o     = DATA_SIZE'(round_sat(64'(acc_q), COEF_FRAC, DATA_SIZE));

  // Accumulator next value selected by the sequencer's control code.
  always_comb begin
    acc_d = acc_q;
    case (op_i)
      MAC_LOAD: acc_d = prod_ext;
      MAC_ADD:  acc_d = acc_q + prod_ext;
      MAC_SUB:  acc_d = acc_q - prod_ext;
      default:  acc_d = acc_q;
    endcase
  end

  // Accumulator register, cleared on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of second-order IIR sections sharing one multiplier. A sample
// accepted on sample_trig walks through every section in seven cycles each;
// the last section's output lands on data_out with a filter_done pulse.
// Handshake: sample_trig is honoured only while busy=0 (else overrun pulses
// the following cycle); busy rises at the accepting edge and falls at the
// edge that raises filter_done; data_out holds between filter_done pulses.
module iir_sos_cascade
  import iir_sos_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 22,
  parameter int COEF_FRAC = 18,
  localparam int ADDR_W   = $clog2(STAGES * 6)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] data_in,
  input  logic                        sample_trig,
  input  logic                        cfg_we,
  input  logic [ADDR_W-1:0]           cfg_addr,
  input  logic signed [COEF_SIZE-1:0] cfg_data,
  output logic signed [DATA_SIZE-1:0] data_out,
  output logic                        filter_done,
  output logic                        busy,
  output logic                        overrun,
  output iir_state_e                  dbg_state
);

  localparam int NCOEF = STAGES * N_COEF;
  localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic signed [COEF_SIZE-1:0] COEF_ONE = COEF_SIZE'(64'd1 << COEF_FRAC);

  iir_state_e state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;

  logic signed [COEF_SIZE-1:0] coef_q [NCOEF];
  logic signed [DATA_SIZE-1:0] x1_q [STAGES];
  logic signed [DATA_SIZE-1:0] x2_q [STAGES];
  logic signed [DATA_SIZE-1:0] y1_q [STAGES];
  logic signed [DATA_SIZE-1:0] y2_q [STAGES];
  logic signed [DATA_SIZE-1:0] in_q;
  logic signed [DATA_SIZE-1:0] data_out_q;
  logic                        done_q;
  logic                        overrun_q;

  logic                        busy_w;
  logic                        last_stage;
  logic signed [DATA_SIZE-1:0] x_cur;
  logic signed [DATA_SIZE-1:0] mac_a;
  logic signed [DATA_SIZE-1:0] mac_rs;
  logic signed [COEF_SIZE-1:0] coef_rd;
  logic [ADDR_W-1:0]           rd_addr;
  int                          coef_idx;
  mac_op_e                     mac_op;

  assign busy_w      = (state_q != ST_IDLE);
  assign last_stage  = (stage_q == SW'(STAGES - 1));
  assign busy        = busy_w;
  assign data_out    = data_out_q;
  assign filter_done = done_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

  // Section input: the latched sample for stage 0, otherwise the previous
  // section's most recent output (its y1 right after its store).
  always_comb begin
    x_cur = in_q;
    if (stage_q != '0) begin
      x_cur = y1_q[stage_q - SW'(1)];
    end
  end

  // Sequencer state and current section index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  // Next state plus per-step multiplier operand and accumulator control.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    mac_op   = MAC_HOLD;
    mac_a    = '0;
    coef_idx = IDX_B0;
    case (state_q)
      ST_IDLE: begin
        if (sample_trig) begin
          state_d = ST_MAC0;
          stage_d = '0;
        end
      end
      ST_MAC0: begin
        mac_op = MAC_LOAD; mac_a = x_cur; coef_idx = IDX_B0; state_d = ST_MAC1;
      end
      ST_MAC1: begin
        mac_op = MAC_ADD; mac_a = x1_q[stage_q]; coef_idx = IDX_B1; state_d = ST_MAC2;
      end
      ST_MAC2: begin
        mac_op = MAC_ADD; mac_a = x2_q[stage_q]; coef_idx = IDX_B2; state_d = ST_MAC3;
      end
      ST_MAC3: begin
        mac_op = MAC_SUB; mac_a = y1_q[stage_q]; coef_idx = IDX_A1; state_d = ST_MAC4;
      end
      ST_MAC4: begin
        mac_op = MAC_SUB; mac_a = y2_q[stage_q]; coef_idx = IDX_A2; state_d = ST_GAIN;
      end
      ST_GAIN: begin
        // rs is the rounded section sum v; scale it by the section gain.
        mac_op = MAC_LOAD; mac_a = mac_rs; coef_idx = IDX_GAIN; state_d = ST_STORE;
      end
      ST_STORE: begin
        if (last_stage) begin
          state_d = ST_IDLE;
        end else begin
          stage_d = stage_q + SW'(1);
          state_d = ST_MAC0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_addr = ADDR_W'(32'(stage_q) * N_COEF + coef_idx);
  assign coef_rd = coef_q[rd_addr];

  sos_mac #(
    .DATA_SIZE(DATA_SIZE),
    .COEF_SIZE(COEF_SIZE),
    .COEF_FRAC(COEF_FRAC)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .op_i  (mac_op),
    .a_i   (mac_a),
    .b_i   (coef_rd),
    .rs_o  (mac_rs)
  );

  // Coefficient bank: passthrough defaults, writable only while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NCOEF; k++) begin
        coef_q[k] <= (((k % N_COEF) == IDX_B0) || ((k % N_COEF) == IDX_GAIN)) ? COEF_ONE : '0;
      end
    end else if (cfg_we && !busy_w && (32'(cfg_addr) < NCOEF)) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  // Sample latch, per-section history, output register and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_q       <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      overrun_q <= sample_trig && busy_w;
      if ((state_q == ST_IDLE) && sample_trig) begin
        in_q <= data_in;
      end
      if (state_q == ST_STORE) begin
        x2_q[stage_q] <= x1_q[stage_q];
        x1_q[stage_q] <= x_cur;
        y2_q[stage_q] <= y1_q[stage_q];
        y1_q[stage_q] <= mac_rs;
        if (last_stage) begin
          data_out_q <= mac_rs;
          done_q     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Directed and randomised checks of the SOS cascade against a plain
// arithmetic model of the difference equations.
module tb_iir_sos_cascade;
  import iir_sos_pkg::*;

  localparam int STAGES = 2;
  localparam int DW     = 24;
  localparam int CW     = 22;
  localparam int CF     = 18;
  localparam int NC     = STAGES * 6;
  localparam int LAT    = 7 * STAGES;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          sample_trig = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [DW-1:0] data_out;
  logic          filter_done;
  logic          busy;
  logic          overrun;
  iir_state_e    dbg_state;

  iir_sos_cascade #(
    .STAGES(STAGES), .DATA_SIZE(DW), .COEF_SIZE(CW), .COEF_FRAC(CF)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sample_trig(sample_trig),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .data_out(data_out), .filter_done(filter_done), .busy(busy),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  longint mcoef [NC];
  longint mx1 [STAGES];
  longint mx2 [STAGES];
  longint my1 [STAGES];
  longint my2 [STAGES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx24(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sx22(input logic [21:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rsat(input longint v);
    longint r, hi, lo;
    r  = (v + (longint'(1) <<< (CF - 1))) >>> CF;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) mcoef[i] = ((i % 6) == 0 || (i % 6) == 5) ? (longint'(1) <<< CF) : 0;
    for (int s = 0; s < STAGES; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic longint model_filter(input longint xin);
    longint x, acc, v, y;
    x = xin;
    for (int s = 0; s < STAGES; s++) begin
      acc = mcoef[s*6+0] * x + mcoef[s*6+1] * mx1[s] + mcoef[s*6+2] * mx2[s]
          - mcoef[s*6+3] * my1[s] - mcoef[s*6+4] * my2[s];
      v = rsat(acc);
      y = rsat(v * mcoef[s*6+5]);
      mx2[s] = mx1[s]; mx1[s] = x;
      my2[s] = my1[s]; my1[s] = y;
      x = y;
    end
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; sample_trig = 1'b0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input int addr, input logic [CW-1:0] val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = val;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr < NC) mcoef[addr] = sx22(val);
  endtask

  // mode: 0 plain, 1 extra trigger while busy, 2 write while busy,
  // 3 write in the same idle cycle as the trigger.
  task automatic run_sample(input string tag, input logic [DW-1:0] x, input int mode,
                            input int waddr, input logic [CW-1:0] wdata);
    longint exp_y;
    logic [DW-1:0] exp_v;
    int done_k;
    bit busy_bad;
    @(negedge clk);
    data_in = x; sample_trig = 1'b1;
    if (mode == 3) begin
      cfg_we = 1'b1; cfg_addr = 4'(waddr); cfg_data = wdata;
      mcoef[waddr] = sx22(wdata);
    end
    exp_y = model_filter(sx24(x));
    exp_v = exp_y[DW-1:0];
    @(negedge clk);
    sample_trig = 1'b0; cfg_we = 1'b0;
    done_k = -1; busy_bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (mode == 1 && k == 2) begin sample_trig = 1'b1; data_in = ~x; end
      if (mode == 1 && k == 3) begin
        sample_trig = 1'b0;
        check({tag, " overrun pulse"}, 64'(overrun), 64'(1));
      end
      if (mode == 1 && k == 4) check({tag, " overrun single"}, 64'(overrun), 64'(0));
      if (mode == 2 && k == 5) begin cfg_we = 1'b1; cfg_addr = 4'(waddr); cfg_data = wdata; end
      if (mode == 2 && k == 6) cfg_we = 1'b0;
      if (filter_done) begin done_k = k; break; end
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
    end
    sample_trig = 1'b0; cfg_we = 1'b0;
    check({tag, " latency"}, 64'(done_k), 64'(LAT));
    check({tag, " busy held"}, 64'(busy_bad), 64'(0));
    check({tag, " busy cleared"}, 64'(busy), 64'(0));
    check({tag, " data_out"}, 64'(data_out), 64'(exp_v));
    @(negedge clk);
    check({tag, " done width"}, 64'(filter_done), 64'(0));
    check({tag, " data_out hold"}, 64'(data_out), 64'(exp_v));
  endtask

  initial begin
    int c;
    bit done_seen;
    model_reset();

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst data_out", 64'(data_out), 64'(0));
    check("rst filter_done", 64'(filter_done), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst overrun", 64'(overrun), 64'(0));
    check("rst state", 64'(dbg_state), 64'(ST_IDLE));

    // Passthrough defaults
    run_sample("pass", 24'h100000, 0, 0, '0);

    // Half gain on stage 0, including round-half-up of -1
    cfg_write(5, 22'd131072);
    run_sample("gain half", 24'h100000, 0, 0, '0);
    run_sample("gain neg1", 24'hFFFFFF, 0, 0, '0);

    // Saturation both signs
    do_reset();
    cfg_write(0, 22'd1048576);
    run_sample("sat pos", 24'h400000, 0, 0, '0);
    run_sample("sat neg", 24'hC00000, 0, 0, '0);

    // FIR taps: impulse response
    do_reset();
    cfg_write(0, 22'd262144); cfg_write(1, 22'd262144); cfg_write(2, 22'd262144);
    run_sample("fir imp", 24'd1000, 0, 0, '0);
    for (int i = 0; i < 4; i++) run_sample("fir zero", 24'd0, 0, 0, '0);

    // Feedback: step through a1 = -0.5
    do_reset();
    cfg_write(3, 22'(-131072));
    for (int i = 0; i < 4; i++) run_sample("step", 24'd1024, 0, 0, '0);

    // Trigger while busy is dropped
    run_sample("ovr", 24'd2048, 1, 0, '0);
    run_sample("ovr after", 24'd512, 0, 0, '0);

    // Write while busy is ignored (gain of last stage would zero the output)
    run_sample("busy wr", 24'd4096, 2, 11, '0);
    run_sample("busy wr after", 24'd4096, 0, 0, '0);

    // Write and trigger in the same idle cycle
    do_reset();
    run_sample("same cyc", 24'h100000, 3, 5, 22'd131072);

    // Abort mid-run with reset
    do_reset();
    cfg_write(0, 22'd524288);
    @(negedge clk);
    data_in = 24'h012345; sample_trig = 1'b1;
    @(negedge clk);
    sample_trig = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    done_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (filter_done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("abort no done", 64'(done_seen), 64'(0));
    check("abort data_out", 64'(data_out), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort state", 64'(dbg_state), 64'(ST_IDLE));
    run_sample("abort defaults", 24'h012345, 0, 0, '0);

    // Randomised coefficients and samples
    do_reset();
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < 3; i++) begin
        c = int'($urandom_range(0, 131072)) - 65536;
        cfg_write(s*6 + i, 22'(c));
      end
      c = int'($urandom_range(0, 262144)) - 131072;
      cfg_write(s*6 + 3, 22'(c));
      c = int'($urandom_range(0, 131072)) - 65536;
      cfg_write(s*6 + 4, 22'(c));
      c = int'($urandom_range(131072, 524288));
      cfg_write(s*6 + 5, 22'(c));
    end
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) cfg_write(NC + int'($urandom_range(0, 3)), 22'($urandom));
      run_sample("rand", 24'($urandom), 0, 0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_sos_cascade.md
# iir_sos_cascade

Parametrised cascade of second-order IIR sections that replaces single fixed-coefficient SOS wrappers. One time-multiplexed multiplier evaluates all sections in sequence. Coefficients live in a run-time writable bank that resets to passthrough. The block sits between the sample source and the downstream output path and uses the existing sample_trig / filter_done handshake.

## Interface
- STAGES, 2: number of cascaded sections (1..8).
- DATA_SIZE, 24: signed sample width.
- COEF_SIZE, 22: signed coefficient width.
- COEF_FRAC, 18: fractional bits of every coefficient (1.0 = 2^COEF_FRAC).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- data_in  in  DATA_SIZE  signed input sample, captured on the accepted sample_trig.
- sample_trig  in  1  one-cycle request to filter data_in.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  clog2(STAGES*6)  coefficient address = stage*6 + index (0 b0, 1 b1, 2 b2, 3 a1, 4 a2, 5 gain).
- cfg_data  in  COEF_SIZE  signed coefficient value.
- data_out  out  DATA_SIZE  filtered sample, held until the next completion.
- filter_done  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high from trigger acceptance until the completion edge.
- overrun  out  1  one-cycle pulse when sample_trig is dropped.

## Operation
- Each stage computes acc = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2, exact, in a DATA_SIZE+COEF_SIZE+4-bit accumulator.
- v = sat(round(acc >> COEF_FRAC)) to DATA_SIZE bits.
- y = sat(round(v·gain >> COEF_FRAC)).
- y is the next stage's x. The last stage's y becomes data_out.
- Rounding: add 2^(COEF_FRAC−1), then arithmetic shift (round half up).
- Saturation clamps to 2^(DATA_SIZE−1)−1 / −2^(DATA_SIZE−1).
- History update at each stage's STORE: x2←x1, x1←x, y2←y1, y1←y. Stored y is post-gain and saturated.
- FSM states: IDLE → MAC0..MAC4 → GAIN → STORE.
  - STORE → MAC0 of the next stage, or → IDLE after the last stage.
  - Each stage takes 7 cycles.
- Coefficient bank:
  - Reset values: b0 = gain = 2^COEF_FRAC; all other coefficients 0. This is passthrough.
  - Writes are accepted only while busy=0.
  - Writes while busy=1, or with cfg_addr ≥ STAGES*6, are ignored.
- sample_trig while busy=1 is ignored and pulses overrun the next cycle. Filter state is unaffected.
- sample_trig and cfg_we in the same IDLE cycle: both take effect. The write is visible to that same computation.
- Reset (reset=0 at an edge) clears:
  - all x/y history, data_out, filter_done, busy and overrun to 0;
  - the coefficient bank to its defaults;
  - the FSM to IDLE.
- Reset mid-computation aborts with no filter_done.

## Timing
- sample_trig sampled high in IDLE at edge T: data_in is latched, and busy=1 from T.
- The final STORE occurs at edge T+7·STAGES. At that edge data_out updates, filter_done=1 for one cycle, and busy=0.
- Latency is 14 cycles for STAGES=2.
- A new sample_trig is accepted at the earliest one cycle after completion, at edge T+7·STAGES+1.
- Minimum trigger period is 7·STAGES+1 cycles.
- overrun is registered: high in the cycle after the rejected trigger.
- data_out is stable between filter_done pulses.

## Structure
- Package iir_sos_pkg holds:
  - coefficient index constants (IDX_B0..IDX_GAIN);
  - the FSM state enum;
  - the round-and-saturate function parameterised by widths.
- Sub-module sos_mac holds the single signed multiplier, the accumulator with clear/add/sub control, and the round/saturate output. The top level holds the FSM, coefficient bank and history registers.

## Test plan
- After reset, with STAGES=2 and default coefficients: data_in=0x100000 with trig → data_out=0x100000, filter_done 14 cycles later for exactly 1 cycle, busy high 14 cycles.
- Write stage0 gain=131072 (0.5): data_in=0x100000 → 0x080000. data_in=0xFFFFFF (−1) → 0x000000 (round half up).
- Write stage0 b0=1048576 (4.0): input 0x400000 → 0x7FFFFF. Input 0xC00000 → 0x800000 (saturation both signs).
- Write stage0 b0=b1=b2=262144: impulse 1000, then zeros on successive triggers → 1000, 1000, 1000, 0, 0.
- Write stage0 a1=−131072 (−0.5), all else default: step of 1024 → 1024, 1536, 1792, 1920.
- Error and reset cases:
  - sample_trig at busy cycle 3 → ignored, overrun pulse, result unchanged.
  - cfg_we while busy → coefficient unchanged.
  - reset=0 mid-run → no filter_done, data_out=0, defaults restored.
